demux1to4_stream: RTL and testbench

- Registered 1-to-4 demultiplexer for a valid/ready byte stream; the inverse of the team's 4:1 select mux.
- Steers each accepted input beat to one of four output channels, chosen either by an explicit 2-bit select or by an internal round-robin pointer.
- Each output has a one-entry holding register; per-channel transfer counters support debug.
- Sits between a single producer and four independent consumers.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_slot.sv | 49 ++++
 rtl/demux1to4_stream.sv | 89 ++++++++
 tb/tb_demux1to4_stream.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

   localparam int unsigned NUM_OUT = 4;
   localparam int unsigned SEL_W   = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // Saturating increment: holds at max_val instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                           input logic [31:0] max_val);
      return (count >= max_val) ? count : count + 32'd1;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : write load_data into the slot on the next edge
//   load_data   : payload to capture
//   out_data    : held payload (retains last value when empty)
//   out_valid   : slot holds a beat
//   out_ready   : consumer takes the beat this cycle
module demux_slot #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;

   // Load wins over drain so a same-cycle accept+drain keeps the slot full.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 demultiplexer for a valid/ready byte stream.
//   in_data/in_valid/in_ready : producer side
//   in_sel, rr_mode           : explicit target or round-robin targeting
//   out_data/out_valid/out_ready : four independent consumer channels
//   rr_ptr                    : current round-robin pointer
//   xfer_cnt                  : per-channel saturating accepted-beat counters
module demux1to4_stream
   import demux_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            in_data,
   input  logic [1:0]               in_sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     rr_mode,
   output logic [NUM_OUT*DW-1:0]    out_data,
   output logic [NUM_OUT-1:0]       out_valid,
   input  logic [NUM_OUT-1:0]       out_ready,
   output logic [1:0]               rr_ptr,
   output logic [NUM_OUT*CNT_W-1:0] xfer_cnt
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   sel_t               tgt_c;
   logic               accept_c;
   logic [NUM_OUT-1:0] load_c;
   sel_t               rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   cnt_q [NUM_OUT];
   logic [CNT_W-1:0]   cnt_d [NUM_OUT];

   // Target mux, flow control and next-state for pointer and counters.
   // A blocked round-robin target keeps in_ready low, so order is never skipped.
   always_comb begin
      tgt_c    = rr_mode ? rr_ptr_q : sel_t'(in_sel);
      in_ready = rst_n & (~out_valid[tgt_c] | out_ready[tgt_c]);
      accept_c = in_valid & in_ready;
      load_c   = '0;
      if (accept_c) begin
         load_c[tgt_c] = 1'b1;
      end
      rr_ptr_d = rr_ptr_q;
      if (accept_c && rr_mode) begin
         rr_ptr_d = rr_ptr_q + sel_t'(1);
      end
      for (int k = 0; k < NUM_OUT; k++) begin
         cnt_d[k] = load_c[k] ? CNT_W'(sat_inc(32'(cnt_q[k]), CNT_MAX)) : cnt_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         for (int k = 0; k < NUM_OUT; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int k = 0; k < NUM_OUT; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_slot #(.DW(DW)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load_c[k]),
         .load_data (in_data),
         .out_data  (out_data[k*DW +: DW]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k])
      );
   end

   always_comb begin
      for (int k = 0; k < NUM_OUT; k++) begin
         xfer_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
      end
   end

   assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_demux1to4_stream.sv
// Scoreboard bench for demux1to4_stream: per-channel expected-beat queues,
// a stimulus process that predicts accepts, and a monitor that checks drains.
module tb_demux1to4_stream;

   localparam int unsigned DW    = 8;
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [DW-1:0]    in_data;
   logic [1:0]       in_sel;
   logic             in_valid;
   logic             in_ready;
   logic             rr_mode;
   logic [4*DW-1:0]  out_data;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [1:0]       rr_ptr;
   logic [4*CNT_W-1:0] xfer_cnt;

   demux1to4_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rr_mode   (rr_mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rr_ptr    (rr_ptr),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: beats owed by each channel, in order; counters; pointer.
   logic [DW-1:0] exp_q [4][$];
   int            m_cnt [4];
   logic [1:0]    m_ptr;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive on negedge, predict handshake, update model at posedge.
   task automatic step(input bit rst, input bit vld, input logic [DW-1:0] d,
                       input logic [1:0] sel, input bit rr, input logic [3:0] ordy);
      logic [1:0] tgt;
      bit         exp_rdy;
      bit         acc;
      @(negedge clk);
      rst_n     = rst;
      in_valid  = vld;
      in_data   = d;
      in_sel    = sel;
      rr_mode   = rr;
      out_ready = ordy;
      #1;
      tgt     = rr ? m_ptr : sel;
      exp_rdy = rst && ((exp_q[tgt].size() == 0) || ordy[tgt]);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      acc = vld && exp_rdy;
      @(posedge clk);
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            m_cnt[k] = 0;
         end
         m_ptr = 2'd0;
      end else if (acc) begin
         exp_q[tgt].push_back(d);
         m_cnt[tgt] = (m_cnt[tgt] + 1 > 3) ? 3 : m_cnt[tgt] + 1;
         if (rr) m_ptr = m_ptr + 2'd1;
      end
   endtask

   // Monitor: compares presented outputs with the model and retires drained beats.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
               if (exp_q[k].size() != 0) begin
                  chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DW +: DW]), 32'(exp_q[k][0]));
                  if (out_ready[k]) void'(exp_q[k].pop_front());
               end
               chk($sformatf("xfer_cnt[%0d]", k), 32'(xfer_cnt[k*CNT_W +: CNT_W]), 32'(m_cnt[k]));
            end
            chk("rr_ptr", 32'(rr_ptr), 32'(m_ptr));
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
      rr_mode = 1'b0; out_ready = 4'hF; m_ptr = 2'd0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;

      // Reset held two cycles with in_valid high.
      step(0, 1, 8'hEE, 2'd1, 0, 4'hF);
      step(0, 1, 8'hEE, 2'd1, 0, 4'hF);
      mon_en = 1'b1;
      #2;
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset xfer_cnt", 32'(xfer_cnt), 32'h0);

      // Select mode, one beat per channel.
      for (int k = 0; k < 4; k++) step(1, 1, 8'(8'hA0 + k), 2'(k), 0, 4'hF);
      step(1, 0, 8'h00, 2'd0, 0, 4'hF);
      #2;
      chk("sel xfer_cnt", 32'(xfer_cnt), 32'h55);
      chk("sel rr_ptr", 32'(rr_ptr), 32'h0);

      // Back-pressure on channel 2 does not block channel 0.
      step(1, 1, 8'h11, 2'd2, 0, 4'b1011);
      step(1, 1, 8'h22, 2'd2, 0, 4'b1011);
      chk("bp in_ready low", 32'(in_ready), 32'h0);
      step(1, 1, 8'h33, 2'd0, 0, 4'b1011);
      step(1, 1, 8'h22, 2'd2, 0, 4'b1111);
      step(1, 0, 8'h00, 2'd0, 0, 4'hF);

      // Round-robin, all ready: six beats, pointer ends at 2.
      for (int i = 0; i < 6; i++) step(1, 1, 8'(i + 1), 2'd0, 1, 4'hF);
      #2;
      chk("rr ptr after 6", 32'(rr_ptr), 32'h2);
      // Channel 1 stalled: fill it, then the next beat for channel 1 waits.
      for (int i = 0; i < 7; i++) step(1, 1, 8'(8'h40 + i), 2'd0, 1, 4'b1101);
      step(1, 1, 8'h50, 2'd0, 1, 4'b1101);
      chk("rr stall in_ready", 32'(in_ready), 32'h0);
      chk("rr stall ptr", 32'(rr_ptr), 32'h1);
      step(1, 1, 8'h50, 2'd0, 1, 4'b1101);
      step(1, 1, 8'h50, 2'd0, 1, 4'b1111);
      step(1, 0, 8'h00, 2'd0, 1, 4'hF);
      #2;
      chk("rr ptr after free", 32'(rr_ptr), 32'h2);

      // Counter saturation on channel 3.
      step(0, 0, 8'h00, 2'd0, 0, 4'hF);
      for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hC0 + i), 2'd3, 0, 4'hF);
      step(1, 0, 8'h00, 2'd0, 0, 4'hF);
      #2;
      chk("sat xfer_cnt[3]", 32'(xfer_cnt[3*CNT_W +: CNT_W]), 32'h3);

      // Reset while channels 0 and 1 hold beats.
      step(1, 1, 8'hD0, 2'd0, 0, 4'h0);
      step(1, 1, 8'hD1, 2'd1, 0, 4'h0);
      step(0, 0, 8'h00, 2'd0, 0, 4'hF);
      step(1, 0, 8'h00, 2'd0, 0, 4'hF);
      #2;
      chk("midreset out_valid", 32'(out_valid), 32'h0);
      chk("midreset xfer_cnt", 32'(xfer_cnt), 32'h0);

      // Randomized traffic with mode changes and occasional resets.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
              8'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
      end
      step(1, 0, 8'h00, 2'd0, 0, 4'hF);
      step(1, 0, 8'h00, 2'd0, 0, 4'hF);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
